// File: rtl/pll_cfg_shifter.sv
// pll_cfg_shifter
//   Serial configuration shifter for the PLL_B programming port. One START
//   in idle launches a transaction: CFG_W bits go out on SDI MSB first, each
//   bit framed by one SCLK low half-period and one SCLK high half-period of
//   CLKDIV system clocks. SDO is sampled at the end of every high
//   half-period. A LATCH strobe of CLKDIV clocks finishes the transaction,
//   and DONE pulses for one cycle.
//
// Ports
//   CLK       system clock; all state changes on its rising edge
//   RESET     synchronous, active-high reset
//   START     transaction request, sampled only while idle
//   CFG_DATA  word to shift out, captured on the accepting START cycle
//   BUSY      high from the first SHIFT_LO cycle through the last LATCH cycle
//   DONE      one-cycle pulse in the first idle cycle after LATCH
//   RDATA     readback word assembled from SDO, updated only at completion
//   SCLK      serial clock to PLL_B
//   SDI       serial data to PLL_B
//   LATCH     load strobe to PLL_B
//   SDO       serial readback from PLL_B
module pll_cfg_shifter #(
  parameter int unsigned CFG_W  = 32,
  parameter int unsigned CLKDIV = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [CFG_W-1:0] CFG_DATA,
  output logic             BUSY,
  output logic             DONE,
  output logic [CFG_W-1:0] RDATA,
  output logic             SCLK,
  output logic             SDI,
  output logic             LATCH,
  input  logic             SDO
);

  // Half-period counter runs 0..CLKDIV-1, bit counter runs 0..CFG_W-1.
  localparam int unsigned HC_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int unsigned BC_W = $clog2(CFG_W);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLKDIV - 1);
  localparam logic [HC_W-1:0] HC_ONE  = HC_W'(1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(CFG_W - 1);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH_ST
  } state_t;

  state_t           r_state;
  logic [HC_W-1:0]  r_hcnt;
  logic [BC_W-1:0]  r_bcnt;
  // r_tx holds the bits still to be sent, next bit at the MSB; the bit on
  // the wire lives in r_sdi, so r_tx is pre-shifted by one at load time.
  logic [CFG_W-1:0] r_tx;
  logic [CFG_W-1:0] r_rx;
  logic [CFG_W-1:0] r_rdata;
  logic             r_busy;
  logic             r_done;
  logic             r_sclk;
  logic             r_sdi;
  logic             r_latch;

  wire w_hc_last = (r_hcnt == HC_LAST);
  wire w_bc_last = (r_bcnt == BC_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_bcnt  <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sdi   <= 1'b0;
      r_latch <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_tx    <= {CFG_DATA[CFG_W-2:0], 1'b0};
            r_sdi   <= CFG_DATA[CFG_W-1];
            r_hcnt  <= '0;
            r_bcnt  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT_LO;
          end
        end

        S_SHIFT_LO: begin
          if (w_hc_last) begin
            r_hcnt  <= '0;
            r_sclk  <= 1'b1;
            r_state <= S_SHIFT_HI;
          end else begin
            r_hcnt <= r_hcnt + HC_ONE;
          end
        end

        S_SHIFT_HI: begin
          if (w_hc_last) begin
            r_hcnt <= '0;
            r_sclk <= 1'b0;
            r_rx   <= {r_rx[CFG_W-2:0], SDO};
            if (w_bc_last) begin
              r_sdi   <= 1'b0;
              r_latch <= 1'b1;
              r_state <= S_LATCH_ST;
            end else begin
              r_bcnt  <= r_bcnt + BC_ONE;
              r_sdi   <= r_tx[CFG_W-1];
              r_tx    <= {r_tx[CFG_W-2:0], 1'b0};
              r_state <= S_SHIFT_LO;
            end
          end else begin
            r_hcnt <= r_hcnt + HC_ONE;
          end
        end

        S_LATCH_ST: begin
          if (w_hc_last) begin
            r_hcnt  <= '0;
            r_latch <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_rdata <= r_rx;
            r_state <= S_IDLE;
          end else begin
            r_hcnt <= r_hcnt + HC_ONE;
          end
        end

        default: begin
          r_sclk  <= 1'b0;
          r_sdi   <= 1'b0;
          r_latch <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign BUSY  = r_busy;
  assign DONE  = r_done;
  assign RDATA = r_rdata;
  assign SCLK  = r_sclk;
  assign SDI   = r_sdi;
  assign LATCH = r_latch;

endmodule

// File: tb/tb_pll_cfg_shifter.sv
// Self-checking bench for pll_cfg_shifter.
//   u_a: CFG_W=8,  CLKDIV=2, SDO selectable (loopback / 0 / 1 / inverted)
//   u_b: CFG_W=8,  CLKDIV=1, SDO tied high
//   u_c: CFG_W=12, CLKDIV=3, SDO looped back, random data
module tb_pll_cfg_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // DUT A
  logic       start_a;
  logic [7:0] data_a;
  logic       busy_a, done_a, sclk_a, sdi_a, latch_a, sdo_a;
  logic [7:0] rdata_a;
  logic [1:0] sdo_mode;

  always_comb begin
    sdo_a = 1'b0;
    case (sdo_mode)
      2'd0:    sdo_a = sdi_a;
      2'd1:    sdo_a = 1'b0;
      2'd2:    sdo_a = 1'b1;
      default: sdo_a = ~sdi_a;
    endcase
  end

  pll_cfg_shifter #(.CFG_W(8), .CLKDIV(2)) u_a (
    .CLK(clk), .RESET(rst), .START(start_a), .CFG_DATA(data_a),
    .BUSY(busy_a), .DONE(done_a), .RDATA(rdata_a), .SCLK(sclk_a),
    .SDI(sdi_a), .LATCH(latch_a), .SDO(sdo_a)
  );

  // DUT B
  logic       start_b;
  logic [7:0] data_b;
  logic       busy_b, done_b, sclk_b, sdi_b, latch_b;
  logic [7:0] rdata_b;

  pll_cfg_shifter #(.CFG_W(8), .CLKDIV(1)) u_b (
    .CLK(clk), .RESET(rst), .START(start_b), .CFG_DATA(data_b),
    .BUSY(busy_b), .DONE(done_b), .RDATA(rdata_b), .SCLK(sclk_b),
    .SDI(sdi_b), .LATCH(latch_b), .SDO(1'b1)
  );

  // DUT C
  logic        start_c;
  logic [11:0] data_c;
  logic        busy_c, done_c, sclk_c, sdi_c, latch_c;
  logic [11:0] rdata_c;

  pll_cfg_shifter #(.CFG_W(12), .CLKDIV(3)) u_c (
    .CLK(clk), .RESET(rst), .START(start_c), .CFG_DATA(data_c),
    .BUSY(busy_c), .DONE(done_c), .RDATA(rdata_c), .SCLK(sclk_c),
    .SDI(sdi_c), .LATCH(latch_c), .SDO(sdi_c)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard for DUT A: pushed when START is driven, popped on DONE.
  typedef struct {
    logic [7:0] data;
    logic [7:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl[NV];

  // Continuous protocol monitor for DUT A.
  logic       p_sclk = 1'b0, p_sdi = 1'b0, p_busy = 1'b0, p_done = 1'b0;
  int         run = 0, nbits = 0;
  logic [7:0] cap = '0;

  always @(negedge clk) begin : mon_a
    sb_t e;
    if (sclk_a)  chk("sdi_stable_hi", sdi_a, p_sdi);
    if (latch_a) chk("latch_vs_sclk", sclk_a, 0);
    if (!busy_a) chk("idle_lines", {sclk_a, sdi_a, latch_a}, 0);
    if (sclk_a && !p_sclk) begin
      cap   = {cap[6:0], sdi_a};
      nbits++;
    end
    if (busy_a) run++;
    if (done_a) begin
      chk("done_width", p_done, 0);
      chk("done_after_busy", p_busy, 1);
      chk("busy_in_done", busy_a, 0);
      chk("busy_len", run, 34);
      chk("done_queue_depth", sbq.size() > 0, 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("rdata", rdata_a, e.exp);
        chk("sdi_seq", cap, e.data);
        chk("sdi_bits", nbits, 8);
      end
    end
    if (p_busy && !busy_a) begin
      run   = 0;
      nbits = 0;
      cap   = '0;
    end
    p_sclk = sclk_a;
    p_sdi  = sdi_a;
    p_busy = busy_a;
    p_done = done_a;
  end

  task automatic wait_done(input int maxc, input string nm);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done_a) break;
    end
    chk(nm, done_a, 1);
  endtask

  initial begin
    rst      = 1'b1;
    start_a  = 1'b0; data_a = '0; sdo_mode = 2'd0;
    start_b  = 1'b0; data_b = '0;
    start_c  = 1'b0; data_c = '0;

    tbl[0] = '{8'hA5, 2'd0, 8'hA5};
    tbl[1] = '{8'h00, 2'd0, 8'h00};
    tbl[2] = '{8'hFF, 2'd0, 8'hFF};
    tbl[3] = '{8'h81, 2'd1, 8'h00};
    tbl[4] = '{8'h3C, 2'd2, 8'hFF};
    tbl[5] = '{8'h96, 2'd3, 8'h69};
    for (int i = 6; i < NV; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      tbl[i] = '{d, 2'd0, d};
    end

    repeat (3) @(negedge clk);
    chk("rst_outs_a", {busy_a, done_a, sclk_a, sdi_a, latch_a, rdata_a}, 0);
    chk("rst_outs_b", {busy_b, done_b, sclk_b, sdi_b, latch_b, rdata_b}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single transactions
    for (int i = 0; i < NV; i++) begin
      sdo_mode = tbl[i].mode;
      data_a   = tbl[i].data;
      start_a  = 1'b1;
      sbq.push_back('{tbl[i].data, tbl[i].exp});
      @(negedge clk);
      start_a = 1'b0;
      chk("busy_rise", busy_a, 1);
      wait_done(100, "vec_done");
      @(negedge clk);
      chk("done_pulse_end", done_a, 0);
    end

    // START pulsed repeatedly mid-transaction, CFG_DATA disturbed too
    sdo_mode = 2'd0;
    data_a   = 8'h3C;
    start_a  = 1'b1;
    sbq.push_back('{8'h3C, 8'h3C});
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      start_a = (k % 2) == 1;
      data_a  = 8'($urandom);
    end
    start_a = 1'b0;
    wait_done(40, "pulse_done");
    repeat (20) @(negedge clk);
    chk("pulse_no_requeue", busy_a, 0);

    // START held high: three back-to-back transactions
    data_a = 8'h5A;
    repeat (3) sbq.push_back('{8'h5A, 8'h5A});
    start_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(60, "b2b_done");
      if (k == 2) start_a = 1'b0;
      else begin
        @(negedge clk);
        chk("b2b_busy", busy_a, 1);
      end
    end
    repeat (50) @(negedge clk);
    chk("b2b_stop", busy_a, 0);
    chk("sb_empty", sbq.size(), 0);

    // Reset on the 5th SHIFT_HI
    begin
      int   r;
      int   seen;
      logic ps;
      data_a  = 8'hC3;
      start_a = 1'b1;
      sbq.push_back('{8'hC3, 8'hC3});
      @(negedge clk);
      start_a = 1'b0;
      r  = 0;
      ps = sclk_a;
      for (int c = 0; c < 100 && r < 5; c++) begin
        @(negedge clk);
        if (sclk_a && !ps) r++;
        ps = sclk_a;
      end
      chk("reach_hi5", r, 5);
      rst = 1'b1;
      sbq.delete();
      @(negedge clk);
      chk("abort_outs", {busy_a, done_a, sclk_a, sdi_a, latch_a, rdata_a}, 0);
      start_a = 1'b1;
      @(negedge clk);
      chk("rst_prio", busy_a, 0);
      start_a = 1'b0;
      rst     = 1'b0;
      seen    = 0;
      repeat (60) begin
        @(negedge clk);
        if (latch_a || done_a || busy_a) seen++;
      end
      chk("abort_quiet", seen, 0);
      data_a  = 8'h96;
      start_a = 1'b1;
      sbq.push_back('{8'h96, 8'h96});
      @(negedge clk);
      start_a = 1'b0;
      wait_done(100, "post_rst_done");
    end

    // DUT B: CLKDIV=1, SDO tied high
    begin
      int         n, ups, lat, patbad;
      logic       psb, es, el;
      logic [7:0] capb;
      n = 0; ups = 0; lat = 0; patbad = 0; psb = 1'b0; capb = '0;
      data_b  = 8'h3C;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      while (busy_b && n < 40) begin
        es = (n < 16) ? ((n % 2) == 1) : 1'b0;
        el = (n == 16);
        if (sclk_b !== es || latch_b !== el) patbad++;
        if (sclk_b && !psb) begin
          ups++;
          capb = {capb[6:0], sdi_b};
        end
        if (latch_b) lat++;
        psb = sclk_b;
        n++;
        @(negedge clk);
      end
      chk("b_busy_len", n, 17);
      chk("b_sclk_rises", ups, 8);
      chk("b_latch_len", lat, 1);
      chk("b_pattern", patbad, 0);
      chk("b_done", done_b, 1);
      chk("b_rdata", rdata_b, 8'hFF);
      chk("b_sdi_seq", capb, 8'h3C);
    end

    // DUT C: random data, CLKDIV=3, loopback
    for (int t = 0; t < 3; t++) begin
      int   c, stbad;
      logic psc, psd;
      data_c  = 12'($urandom);
      start_c = 1'b1;
      @(negedge clk);
      start_c = 1'b0;
      c = 0; stbad = 0; psc = 1'b0; psd = 1'b0;
      while (!done_c && c < 200) begin
        if (sclk_c && sdi_c !== psd) stbad++;
        if (latch_c && sclk_c) stbad++;
        psc = sclk_c;
        psd = sdi_c;
        c++;
        @(negedge clk);
      end
      chk("c_done", done_c, 1);
      chk("c_busy_len", c, 75);
      chk("c_stable", stbad, 0);
      chk("c_rdata", rdata_c, data_c);
      if (psc) stbad++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
